// File: rtl/m_ext_pkg.sv
// Shared types and constants for the M-extension sequencing stage.
package m_ext_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q = '1;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } m_state_e;

  typedef struct packed {
    logic sign;
    logic mix;
    logic mult_or_div;
    logic sel_hi;
  } m_dec_t;

endpackage

// File: rtl/m_ext_decode.sv
// funct3 decode into M-unit controls, plus detection of the divide-by-zero
// and signed-overflow cases whose results are fixed by the ISA.
module m_ext_decode
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output m_dec_t          dec,
  output logic            special,
  output logic [XLEN-1:0] special_result
);

  logic div_zero;
  logic div_ovf;

  always_comb begin
    dec             = '0;
    dec.mult_or_div = funct3[2];
    case (funct3)
      F3_MUL:    begin dec.sign = 1'b0; dec.mix = 1'b0; dec.sel_hi = 1'b0; end
      F3_MULH:   begin dec.sign = 1'b1; dec.mix = 1'b0; dec.sel_hi = 1'b1; end
      F3_MULHSU: begin dec.sign = 1'b1; dec.mix = 1'b1; dec.sel_hi = 1'b1; end
      F3_MULHU:  begin dec.sign = 1'b0; dec.mix = 1'b0; dec.sel_hi = 1'b1; end
      F3_DIV:    begin dec.sign = 1'b1; dec.mix = 1'b0; dec.sel_hi = 1'b1; end
      F3_DIVU:   begin dec.sign = 1'b0; dec.mix = 1'b0; dec.sel_hi = 1'b1; end
      F3_REM:    begin dec.sign = 1'b1; dec.mix = 1'b0; dec.sel_hi = 1'b0; end
      default:   begin dec.sign = 1'b0; dec.mix = 1'b0; dec.sel_hi = 1'b0; end
    endcase
  end

  // Overflow only matters for the signed divide pair; the unsigned ops treat
  // the same bit patterns as ordinary operands.
  always_comb begin
    div_zero = funct3[2] && (b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (a == OVF_Q) && (b == '1);
  end

  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (div_zero) begin
      special        = 1'b1;
      special_result = dec.sel_hi ? DIV0_Q : a;
    end else if (div_ovf) begin
      special        = 1'b1;
      special_result = dec.sel_hi ? OVF_Q : '0;
    end
  end

endmodule

// File: rtl/m_ext_seq.sv
// Valid/ready sequencer around the combinational M unit: holds operands for
// a fixed window, captures the selected half and returns it with its tag.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   EXEC  | operands held on m_*, counter running down to capture
//   DONE  | result valid, held until out_ready
module m_ext_seq
  import m_ext_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [XLEN-1:0]  m_a,
  output logic [XLEN-1:0]  m_b,
  output logic             m_sign,
  output logic             m_mix,
  output logic             m_mult_or_div,
  input  logic [XLEN-1:0]  m_uh,
  input  logic [XLEN-1:0]  m_lh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  m_state_e          state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_q;
  m_dec_t            dec_q;

  m_dec_t            dec;
  logic              special;
  logic [XLEN-1:0]   special_result;
  logic              accept;

  m_ext_decode #(.XLEN(XLEN)) u_decode (
    .funct3         (in_funct3),
    .a              (in_a),
    .b              (in_b),
    .dec            (dec),
    .special        (special),
    .special_result (special_result)
  );

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dec_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            dec_q <= dec;
            tag_q <= in_tag;
            // Fixed-result cases skip the M unit entirely.
            if (special) begin
              result_q <= special_result;
              state_q  <= DONE;
            end else begin
              cnt_q   <= dec.mult_or_div ? DIV_LOAD : MUL_LOAD;
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            result_q <= dec_q.sel_hi ? m_uh : m_lh;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_a           = a_q;
  assign m_b           = b_q;
  assign m_sign        = dec_q.sign;
  assign m_mix         = dec_q.mix;
  assign m_mult_or_div = dec_q.mult_or_div;
  assign out_valid     = (state_q == DONE);
  assign out_result    = result_q;
  assign out_tag       = tag_q;

endmodule

// File: tb/tb_m_ext_seq.sv
// Directed bench for m_ext_seq with a behavioural M unit on the m_* side.
module tb_m_ext_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic [31:0] m_a, m_b;
  logic        m_sign, m_mix, m_mult_or_div;
  logic [31:0] m_uh, m_lh;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m_ext_seq #(.XLEN(32), .MUL_CYCLES(1), .DIV_CYCLES(4), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .m_a(m_a), .m_b(m_b), .m_sign(m_sign), .m_mix(m_mix),
    .m_mult_or_div(m_mult_or_div), .m_uh(m_uh), .m_lh(m_lh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  // Behavioural M unit: 64-bit product halves, or quotient/remainder.
  logic [63:0] ea, eb, prod;
  always_comb begin
    ea   = {{32{m_sign & m_a[31]}}, m_a};
    eb   = {{32{m_sign & ~m_mix & m_b[31]}}, m_b};
    prod = ea * eb;
    m_uh = prod[63:32];
    m_lh = prod[31:0];
    if (m_mult_or_div) begin
      if (m_b == '0) begin
        m_uh = '1;
        m_lh = m_a;
      end else if (m_sign) begin
        if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          m_uh = m_a;
          m_lh = '0;
        end else begin
          m_uh = 32'($signed(m_a) / $signed(m_b));
          m_lh = 32'($signed(m_a) % $signed(m_b));
        end
      end else begin
        m_uh = m_a / m_b;
        m_lh = m_a % m_b;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request from a negedge and return after the accepting edge.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    @(negedge clk);
    chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h5A5A_A5A5;
    in_tag   = 5'd31;
  endtask

  // Edges after the accepting edge until out_valid; operands must hold meanwhile.
  task automatic wait_valid(input logic [31:0] a, input logic [31:0] b, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("hold_a", m_a, a);
      chk("hold_b", m_b, b);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_after_hs", {31'd0, out_valid}, 32'd0);
    chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [2:0] ctl,
                        input int exp_lat, input logic [31:0] exp_res);
    int lat;
    start_op(f3, a, b, tag);
    chk({name, "_ctl"}, {29'd0, m_sign, m_mix, m_mult_or_div}, {29'd0, ctl});
    wait_valid(a, b, lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_res"}, out_result, exp_res);
    chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    handshake();
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [2:0]  ctl;
    int          lat;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;

    vecs.push_back('{"mulh",   3'b001, 32'hFFFF_FFFE, 32'd3,         5'd3,  3'b100, 2, 32'hFFFF_FFFF});
    vecs.push_back('{"mul",    3'b000, 32'd7,         32'd6,         5'd4,  3'b000, 2, 32'h0000_002A});
    vecs.push_back('{"mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd5,  3'b110, 2, 32'hFFFF_FFFF});
    vecs.push_back('{"mulhu",  3'b011, 32'hFFFF_FFFF, 32'd2,         5'd6,  3'b000, 2, 32'h0000_0001});
    vecs.push_back('{"div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd17, 3'b101, 5, 32'hFFFF_FFFD});
    vecs.push_back('{"rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd18, 3'b101, 5, 32'hFFFF_FFFF});
    vecs.push_back('{"divu",   3'b101, 32'd100,       32'd7,         5'd19, 3'b001, 5, 32'h0000_000E});
    vecs.push_back('{"remu",   3'b111, 32'd100,       32'd7,         5'd20, 3'b001, 5, 32'h0000_0002});
    vecs.push_back('{"divu0",  3'b101, 32'h0000_1234, 32'd0,         5'd21, 3'b001, 1, 32'hFFFF_FFFF});
    vecs.push_back('{"remu0",  3'b111, 32'h0000_1234, 32'd0,         5'd22, 3'b001, 1, 32'h0000_1234});
    vecs.push_back('{"div0",   3'b100, 32'd5,         32'd0,         5'd23, 3'b101, 1, 32'hFFFF_FFFF});
    vecs.push_back('{"rem0",   3'b110, 32'd5,         32'd0,         5'd24, 3'b101, 1, 32'h0000_0005});
    vecs.push_back('{"divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 3'b101, 1, 32'h8000_0000});
    vecs.push_back('{"removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 3'b101, 1, 32'h0000_0000});
    vecs.push_back('{"divuovf",3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 3'b001, 5, 32'h0000_0000});

    #12;
    chk("rst_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag",    {27'd0, out_tag}, 32'd0);
    chk("rst_ma",     m_a, 32'd0);
    chk("rst_mb",     m_b, 32'd0);
    chk("rst_ctl",    {29'd0, m_sign, m_mix, m_mult_or_div}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag,
             vecs[i].ctl, vecs[i].lat, vecs[i].res);

    // Back-pressure: result held for 10 cycles while a new request is offered.
    start_op(3'b100, 32'd100, 32'd9, 5'd9);
    wait_valid(32'd100, 32'd9, lat);
    chk("bp_lat", 32'(lat), 32'd5);
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = 3'b000;
    in_a      = 32'd3;
    in_b      = 32'd3;
    in_tag    = 5'd2;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid",  {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'd11);
      chk("bp_tag",    {27'd0, out_tag}, 32'd9);
      chk("bp_ready",  {31'd0, in_ready}, 32'd0);
    end
    handshake();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_no_accept", {31'd0, in_ready}, 32'd1);

    // Flush in the second EXEC cycle of a DIV.
    start_op(3'b100, 32'd50, 32'd5, 5'd11);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("fl_no_result", {31'd0, out_valid}, 32'd0);
    end

    // Flush in IDLE blocks a same-cycle request.
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_funct3 = 3'b101;
    in_b      = 32'd0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_idle_valid", {31'd0, out_valid}, 32'd0);

    // Flush in DONE drops the result.
    start_op(3'b000, 32'd4, 32'd5, 5'd12);
    wait_valid(32'd4, 32'd5, lat);
    chk("fd_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fd_dropped", {31'd0, out_valid}, 32'd0);
    chk("fd_ready",   {31'd0, in_ready}, 32'd1);

    // Async reset mid-EXEC.
    start_op(3'b100, 32'd77, 32'd7, 5'd13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready",  {31'd0, in_ready}, 32'd1);
    chk("ar_valid",  {31'd0, out_valid}, 32'd0);
    chk("ar_ma",     m_a, 32'd0);
    chk("ar_mb",     m_b, 32'd0);
    chk("ar_ctl",    {29'd0, m_sign, m_mix, m_mult_or_div}, 32'd0);
    chk("ar_result", out_result, 32'd0);
    chk("ar_tag",    {27'd0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("ar_post_ready", {31'd0, in_ready}, 32'd1);
      chk("ar_post_valid", {31'd0, out_valid}, 32'd0);
    end

    // Normal operation resumes after reset.
    run_op("post_mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 5'd1, 3'b100, 2, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
